vpu_slide_engine: RTL



---
 rtl/vpu_slide_engine.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vpu_slide_engine.sv
// Multi-cycle vector slide unit: vslideup/vslidedown/vslide1up/vslide1down.
// Walks the destination group one register at a time through one VRF read port.
module vpu_slide_engine #(
  parameter int VLEN    = 64,
  parameter int VL_BITS = $clog2(VLEN) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic [1:0]           op_i,
  input  logic                 vm_i,
  input  logic [1:0]           vsew_i,
  input  logic [1:0]           lmul_i,
  input  logic [VL_BITS-1:0]   vl_i,
  input  logic [63:0]          offset_i,
  input  logic [63:0]          scalar_i,
  input  logic [4:0]           rs2_addr_i,
  input  logic [4:0]           rd_addr_i,
  input  logic [VLEN-1:0]      mask_i,
  output logic                 rs2_read_en_o,
  output logic [4:0]           rs2_read_addr_o,
  input  logic [VLEN-1:0]      rs2_val_i,
  output logic                 result_valid_o,
  output logic [4:0]           result_addr_o,
  output logic [VLEN/8-1:0]    result_bweb_o,
  output logic [VLEN-1:0]      result_data_o
);

  localparam int LOG_VLEN = $clog2(VLEN);
  localparam int NB       = VLEN / 8;
  localparam int SW       = VL_BITS + 2;
  localparam int RW       = LOG_VLEN - 3;

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR, DONE} state_t;

  state_t               state;
  logic [1:0]           op_q;
  logic                 vm_q;
  logic [1:0]           sew_q;
  logic [1:0]           lmul_q;
  logic [VL_BITS-1:0]   vl_q;
  logic [VL_BITS:0]     off_q;
  logic [VL_BITS:0]     n_q;
  logic [VL_BITS-1:0]   k_q;
  logic [63:0]          scalar_q;
  logic [4:0]           rs2_q;
  logic [4:0]           rd_q;
  logic [VLEN-1:0]      mask_q;
  logic [VLEN-1:0]      lo_q;

  // Command decode on the accept edge
  logic [VL_BITS:0]     epr_in;
  logic [VL_BITS:0]     vlmax_in;
  logic [VL_BITS:0]     n_in;
  logic [VL_BITS:0]     off_in;
  logic                 bad_in;

  always_comb begin
    epr_in   = (VL_BITS+1)'(NB) >> vsew_i;
    vlmax_in = epr_in << lmul_i;
    n_in     = ({1'b0, vl_i} + epr_in - (VL_BITS+1)'(1)) >> (RW - int'(vsew_i));
    bad_in   = (vl_i == '0) || ({1'b0, vl_i} > vlmax_in);
    if (op_i[1])
      off_in = (VL_BITS+1)'(1);
    else if (offset_i > 64'(vlmax_in))
      off_in = vlmax_in;
    else
      off_in = offset_i[VL_BITS:0];
  end

  // Source addressing for the current destination register
  int unsigned          log2epr;
  int unsigned          shamt;
  logic [SW-1:0]        kbase;
  logic signed [SW-1:0] s;
  logic signed [SW-1:0] lo_idx;
  logic signed [SW-1:0] hi_idx;
  logic signed [SW-1:0] regs;
  logic [RW-1:0]        emask;
  logic [RW-1:0]        rem;
  logic                 lo_ok;
  logic                 hi_ok;

  always_comb begin
    log2epr = RW - int'(sew_q);
    kbase   = SW'(k_q) << log2epr;
    s       = op_q[0] ? $signed(kbase + SW'(off_q)) : $signed(kbase - SW'(off_q));
    lo_idx  = s >>> log2epr;
    hi_idx  = lo_idx + SW'(1);
    regs    = SW'(1) << lmul_q;
    lo_ok   = !lo_idx[SW-1] && (lo_idx < regs);
    hi_ok   = !hi_idx[SW-1] && (hi_idx < regs);
    emask   = RW'((NB >> sew_q) - 1);
    rem     = s[RW-1:0] & emask;
    shamt   = 32'(rem) << (32'd3 + 32'(sew_q));
  end

  // Element-aligned funnel of {hi, lo}, then per-byte activity and scalar insert
  logic [VLEN-1:0] hi_val;
  logic [VLEN-1:0] shifted;
  logic [NB-1:0]   bweb;
  logic [VLEN-1:0] wdata;

  always_comb begin
    hi_val  = hi_ok ? rs2_val_i : '0;
    shifted = VLEN'({hi_val, lo_q} >> shamt);
    bweb    = '0;
    wdata   = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      logic [SW-1:0] idx;
      logic          is_scalar;
      logic          act;
      idx       = kbase + SW'(b >> sew_q);
      is_scalar = (op_q == 2'b10 && idx == '0) ||
                  (op_q == 2'b11 && idx == SW'(vl_q) - SW'(1));
      act       = (idx < SW'(vl_q)) && (vm_q || mask_q[idx[LOG_VLEN-1:0]]) &&
                  (op_q[0] || idx >= SW'(off_q) || is_scalar);
      if (act) begin
        bweb[b]        = 1'b1;
        wdata[8*b +: 8] = is_scalar ? scalar_q[8*(b & ((32'd1 << sew_q) - 32'd1)) +: 8]
                                    : shifted[8*b +: 8];
      end
    end
  end

  always_comb begin
    rs2_read_en_o   = (state == RD_LO && lo_ok) || (state == RD_HI && hi_ok);
    rs2_read_addr_o = '0;
    if (state == RD_LO && lo_ok)
      rs2_read_addr_o = rs2_q + lo_idx[4:0];
    else if (state == RD_HI && hi_ok)
      rs2_read_addr_o = rs2_q + hi_idx[4:0];
    result_valid_o = (state == WR) && (|bweb);
    result_addr_o  = result_valid_o ? rd_q + k_q[4:0] : '0;
    result_bweb_o  = result_valid_o ? bweb : '0;
    result_data_o  = result_valid_o ? wdata : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      op_q     <= '0;
      vm_q     <= 1'b0;
      sew_q    <= '0;
      lmul_q   <= '0;
      vl_q     <= '0;
      off_q    <= '0;
      n_q      <= '0;
      k_q      <= '0;
      scalar_q <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      mask_q   <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            op_q     <= op_i;
            vm_q     <= vm_i;
            sew_q    <= vsew_i;
            lmul_q   <= lmul_i;
            vl_q     <= vl_i;
            off_q    <= off_in;
            n_q      <= n_in;
            k_q      <= '0;
            scalar_q <= scalar_i;
            rs2_q    <= rs2_addr_i;
            rd_q     <= rd_addr_i;
            mask_q   <= mask_i;
            busy_o   <= 1'b1;
            done_o   <= bad_in;
            state    <= bad_in ? DONE : RD_LO;
          end
        end
        RD_LO: state <= RD_HI;
        RD_HI: begin
          lo_q  <= lo_ok ? rs2_val_i : '0;
          state <= WR;
        end
        WR: begin
          if (({1'b0, k_q} + (VL_BITS+1)'(1)) < n_q) begin
            k_q   <= k_q + VL_BITS'(1);
            state <= RD_LO;
          end else begin
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
